// File: rtl/sprite_fetch_sequencer_if.sv
// Bus bundle between the sprite fetch sequencer and the slot store, OAM, VRAM and pixel shifter.
// The master modport is the sequencer side; the slave modport is the surrounding PPU.
interface sprite_fetch_sequencer_if #(
  parameter int N_SLOTS = 10,
  parameter int IDX_W   = 6,
  parameter int ROW_W   = 4
);
  logic [N_SLOTS-1:0]       match;
  logic [N_SLOTS*IDX_W-1:0] slot_idx;
  logic [N_SLOTS*ROW_W-1:0] slot_row;
  logic                     oam_rd;
  logic [7:0]               oam_a;
  logic [7:0]               oam_d;
  logic                     vram_rd;
  logic [12:0]              vram_a;
  logic [7:0]               vram_d;
  logic                     stall;
  logic                     spr_load;
  logic [7:0]               spr_lo;
  logic [7:0]               spr_hi;
  logic [7:0]               spr_attr;
  logic [N_SLOTS-1:0]       slot_clr;

  modport master (
    input  match, slot_idx, slot_row, oam_d, vram_d,
    output oam_rd, oam_a, vram_rd, vram_a, stall, spr_load, spr_lo, spr_hi, spr_attr, slot_clr
  );

  modport slave (
    output match, slot_idx, slot_row, oam_d, vram_d,
    input  oam_rd, oam_a, vram_rd, vram_a, stall, spr_load, spr_lo, spr_hi, spr_attr, slot_clr
  );
endinterface

// File: rtl/sprite_fetch_sequencer.sv
// Services X-matched sprite slots lowest-first: reads tile/attr from OAM, two pattern bytes from VRAM.
// Optional macro SPRITE_XFLIP_EN: bit-reverse pattern bytes here when attr[5] is set.
module sprite_fetch_sequencer #(
  parameter int N_SLOTS = 10,
  parameter int IDX_W   = 6,
  parameter int ROW_W   = 4
) (
  input  logic clk,
  input  logic nreset,
  input  logic i_spr_en,
  input  logic i_tall,
  input  logic i_bg_ready,
  input  logic i_line_end,
  sprite_fetch_sequencer_if.master bus
);

  localparam int SEL_W = $clog2(N_SLOTS);

  typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_LD} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [SEL_W-1:0]   r_sel;
  logic [IDX_W-1:0]   r_idx;
  logic [ROW_W-1:0]   r_row;
  logic [7:0]         r_tile;
  logic [7:0]         r_attr;
  logic [7:0]         r_lo;
  logic [7:0]         r_hi;
  logic [7:0]         r_out_lo;
  logic [7:0]         r_out_hi;
  logic [7:0]         r_out_attr;
  logic [SEL_W-1:0]   w_low;
  logic               w_any;
  logic               w_start;
  logic [3:0]         w_r;
  logic [7:0]         w_t;
  logic [11:0]        w_pat;
  logic [7:0]         w_lo_fmt;
  logic [7:0]         w_hi_fmt;

  // Priority encoder: scanning downward leaves the lowest set slot in w_low.
  always_comb begin
    w_low = '0;
    for (int k = N_SLOTS - 1; k >= 0; k--) begin
      if (bus.match[k]) w_low = SEL_W'(k);
    end
  end

  assign w_any   = |bus.match;
  assign w_start = (r_state == S_IDLE) & i_spr_en & w_any & i_bg_ready & ~i_line_end;

  assign w_r   = 4'(r_row) ^ (r_attr[6] ? (i_tall ? 4'hF : 4'h7) : 4'h0);
  assign w_t   = i_tall ? {r_tile[7:1], w_r[3]} : r_tile;
  assign w_pat = {1'b0, w_t, w_r[2:0]};

`ifdef SPRITE_XFLIP_EN
  function automatic logic [7:0] f_rev(input logic [7:0] d);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[b] = d[7-b];
    return v;
  endfunction

  assign w_lo_fmt = r_attr[5] ? f_rev(r_lo) : r_lo;
  assign w_hi_fmt = r_attr[5] ? f_rev(r_hi) : r_hi;
`else
  assign w_lo_fmt = r_lo;
  assign w_hi_fmt = r_hi;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_line_end) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_start) w_next = S_T0;
        S_T0:    w_next = S_T1;
        S_T1:    w_next = S_T2;
        S_T2:    w_next = S_T3;
        S_T3:    w_next = S_T4;
        S_T4:    w_next = S_T5;
        S_T5:    w_next = S_LD;
        S_LD:    w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Working registers; the visible spr_* copies only update on a completed (non-aborted) LD.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_sel      <= '0;
      r_idx      <= '0;
      r_row      <= '0;
      r_tile     <= '0;
      r_attr     <= '0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_out_lo   <= '0;
      r_out_hi   <= '0;
      r_out_attr <= '0;
    end else begin
      if (w_start) begin
        r_sel <= w_low;
        r_idx <= bus.slot_idx[w_low*IDX_W +: IDX_W];
        r_row <= bus.slot_row[w_low*ROW_W +: ROW_W];
      end
      if (!i_line_end) begin
        case (r_state)
          S_T1: r_tile <= bus.oam_d;
          S_T2: r_attr <= bus.oam_d;
          S_T4: r_lo   <= bus.vram_d;
          S_T5: r_hi   <= bus.vram_d;
          S_LD: begin
            r_out_lo   <= w_lo_fmt;
            r_out_hi   <= w_hi_fmt;
            r_out_attr <= r_attr;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.stall    = (i_spr_en & w_any) | (r_state != S_IDLE);
    bus.oam_rd   = 1'b0;
    bus.oam_a    = '0;
    bus.vram_rd  = 1'b0;
    bus.vram_a   = '0;
    bus.spr_load = 1'b0;
    bus.slot_clr = '0;
    bus.spr_lo   = r_out_lo;
    bus.spr_hi   = r_out_hi;
    bus.spr_attr = r_out_attr;
    if (!i_line_end) begin
      case (r_state)
        S_T0: begin
          bus.oam_rd = 1'b1;
          bus.oam_a  = {r_idx, 2'b10};
        end
        S_T1: begin
          bus.oam_rd = 1'b1;
          bus.oam_a  = {r_idx, 2'b11};
        end
        S_T3: begin
          bus.vram_rd = 1'b1;
          bus.vram_a  = {w_pat, 1'b0};
        end
        S_T4: begin
          bus.vram_rd = 1'b1;
          bus.vram_a  = {w_pat, 1'b1};
        end
        S_LD: begin
          bus.spr_load = 1'b1;
          bus.slot_clr = N_SLOTS'(1) << r_sel;
          bus.spr_lo   = w_lo_fmt;
          bus.spr_hi   = w_hi_fmt;
          bus.spr_attr = r_attr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_fetch_sequencer.sv
// Directed self-checking bench for sprite_fetch_sequencer with OAM/VRAM memory models.
// Expected flip results follow SPRITE_XFLIP_EN when the bench is built with it.
module tb_sprite_fetch_sequencer;

  logic clk = 1'b0;
  logic nreset;
  logic sprEn, tall, bgReady, lineEnd;
  int   nAssert = 0;
  int   nFail   = 0;

  logic [7:0] oamMem  [256];
  logic [7:0] vramMem [8192];

  sprite_fetch_sequencer_if #(.N_SLOTS(10), .IDX_W(6), .ROW_W(4)) bus ();

  sprite_fetch_sequencer dut (
    .clk        (clk),
    .nreset     (nreset),
    .i_spr_en   (sprEn),
    .i_tall     (tall),
    .i_bg_ready (bgReady),
    .i_line_end (lineEnd),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  // Synchronous memory models: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.oam_rd)  bus.oam_d  <= oamMem[bus.oam_a];
    if (bus.vram_rd) bus.vram_d <= vramMem[bus.vram_a];
  end

  task automatic setSlot(input int k, input logic [5:0] idx, input logic [3:0] row);
    bus.slot_idx[k*6 +: 6] = idx;
    bus.slot_row[k*4 +: 4] = row;
  endtask

  // Called during the IDLE start cycle; advances to the LD cycle capturing the bus addresses.
  task automatic runSeq(output logic [7:0] a2, output logic [7:0] a3,
                        output logic [12:0] v5, output logic [12:0] v6,
                        output int earlyLoads, output int stallLows);
    earlyLoads = 0;
    stallLows  = 0;
    a2 = '0; a3 = '0; v5 = '0; v6 = '0;
    for (int c = 2; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 2) a2 = bus.oam_a;
      if (c == 3) a3 = bus.oam_a;
      if (c == 5) v5 = bus.vram_a;
      if (c == 6) v6 = bus.vram_a;
      if (c < 8 && bus.spr_load) earlyLoads++;
      if (!bus.stall) stallLows++;
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0; sprEn = 1'b0; tall = 1'b0; bgReady = 1'b0; lineEnd = 1'b0;
    bus.match = '0; bus.slot_idx = '0; bus.slot_row = '0;
    repeat (2) @(posedge clk);
    #1;
    nAssert++;
    if ({bus.stall, bus.oam_rd, bus.vram_rd, bus.spr_load} !== 4'b0000) begin
      nFail++; $display("[TB] FAIL reset_strobes: got %b expected 0000", {bus.stall, bus.oam_rd, bus.vram_rd, bus.spr_load});
    end
    nAssert++;
    if ({bus.oam_a, bus.vram_a, bus.slot_clr} !== 31'd0) begin
      nFail++; $display("[TB] FAIL reset_addr: got oam_a %h vram_a %h slot_clr %h expected 0", bus.oam_a, bus.vram_a, bus.slot_clr);
    end
    nAssert++;
    if ({bus.spr_lo, bus.spr_hi, bus.spr_attr} !== 24'd0) begin
      nFail++; $display("[TB] FAIL reset_data: got %h expected 000000", {bus.spr_lo, bus.spr_hi, bus.spr_attr});
    end
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_match();
    logic [7:0] a2, a3; logic [12:0] v5, v6; int early, lows;
    oamMem[8'h16] = 8'h42; oamMem[8'h17] = 8'h00;
    vramMem[13'h426] = 8'h5A; vramMem[13'h427] = 8'hC3;
    setSlot(2, 6'd5, 4'd3);
    tall = 1'b0; bgReady = 1'b1; sprEn = 1'b1; bus.match = 10'h004;
    #1;
    nAssert++;
    if (bus.stall !== 1'b1) begin nFail++; $display("[TB] FAIL single_stall_same_cycle: got %b expected 1", bus.stall); end
    runSeq(a2, a3, v5, v6, early, lows);
    nAssert++;
    if ({a2, a3} !== 16'h1617) begin nFail++; $display("[TB] FAIL single_oam_a: got %h/%h expected 16/17", a2, a3); end
    nAssert++;
    if ({v5, v6} !== {13'h0426, 13'h0427}) begin nFail++; $display("[TB] FAIL single_vram_a: got %h/%h expected 0426/0427", v5, v6); end
    nAssert++;
    if ({early, bus.spr_load} !== {32'd0, 1'b1}) begin nFail++; $display("[TB] FAIL single_load_cycle8: early %0d load %b expected 0 and 1", early, bus.spr_load); end
    nAssert++;
    if (bus.slot_clr !== 10'h004) begin nFail++; $display("[TB] FAIL single_slot_clr: got %h expected 004", bus.slot_clr); end
    nAssert++;
    if ({bus.spr_lo, bus.spr_hi, bus.spr_attr} !== 24'h5AC300) begin
      nFail++; $display("[TB] FAIL single_data: got %h expected 5AC300", {bus.spr_lo, bus.spr_hi, bus.spr_attr});
    end
    bus.match = '0;
    @(posedge clk); #1;
    nAssert++;
    if ({bus.spr_load, bus.slot_clr, bus.stall} !== 12'd0) begin
      nFail++; $display("[TB] FAIL single_after_ld: got load %b clr %h stall %b expected 0", bus.spr_load, bus.slot_clr, bus.stall);
    end
  endtask

  task automatic test_yflip_tall();
    logic [7:0] a2, a3; logic [12:0] v5, v6; int early, lows;
    oamMem[8'h1E] = 8'h43; oamMem[8'h1F] = 8'h40;
    vramMem[13'h43A] = 8'h11; vramMem[13'h43B] = 8'h22;
    setSlot(3, 6'd7, 4'd2);
    tall = 1'b1; bus.match = 10'h008;
    #1;
    runSeq(a2, a3, v5, v6, early, lows);
    nAssert++;
    if ({v5, v6} !== {13'h043A, 13'h043B}) begin nFail++; $display("[TB] FAIL yflip_vram_a: got %h/%h expected 043A/043B", v5, v6); end
    nAssert++;
    if ({bus.spr_lo, bus.spr_hi, bus.spr_attr, bus.slot_clr} !== {24'h112240, 10'h008}) begin
      nFail++; $display("[TB] FAIL yflip_load: got %h clr %h expected 112240 clr 008", {bus.spr_lo, bus.spr_hi, bus.spr_attr}, bus.slot_clr);
    end
    bus.match = '0; tall = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_xflip_macro();
    logic [7:0] a2, a3; logic [12:0] v5, v6; int early, lows;
    logic [15:0] expLoHi;
`ifdef SPRITE_XFLIP_EN
    expLoHi = 16'h80C0;
`else
    expLoHi = 16'h0103;
`endif
    oamMem[8'h2A] = 8'h10; oamMem[8'h2B] = 8'h20;
    vramMem[13'h100] = 8'h01; vramMem[13'h101] = 8'h03;
    setSlot(1, 6'd10, 4'd0);
    bus.match = 10'h002;
    #1;
    runSeq(a2, a3, v5, v6, early, lows);
    nAssert++;
    if ({bus.spr_lo, bus.spr_hi} !== expLoHi) begin nFail++; $display("[TB] FAIL xflip_bytes: got %h expected %h", {bus.spr_lo, bus.spr_hi}, expLoHi); end
    bus.match = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a2, a3; logic [12:0] v5, v6; int early, lows, totalLows;
    oamMem[8'h06] = 8'h20; oamMem[8'h07] = 8'h00;
    oamMem[8'h0A] = 8'h21; oamMem[8'h0B] = 8'h00;
    vramMem[13'h200] = 8'hA1; vramMem[13'h201] = 8'hA2;
    vramMem[13'h212] = 8'hB1; vramMem[13'h213] = 8'hB2;
    setSlot(0, 6'd1, 4'd0);
    setSlot(9, 6'd2, 4'd1);
    bus.match = 10'h201;
    #1;
    totalLows = (bus.stall !== 1'b1) ? 1 : 0;
    runSeq(a2, a3, v5, v6, early, lows);
    totalLows += lows;
    nAssert++;
    if ({bus.slot_clr, bus.spr_lo, a2} !== {10'h001, 8'hA1, 8'h06}) begin
      nFail++; $display("[TB] FAIL b2b_first: got clr %h lo %h oam_a %h expected 001 A1 06", bus.slot_clr, bus.spr_lo, a2);
    end
    bus.match = 10'h200;
    @(posedge clk); #1;
    if (bus.stall !== 1'b1) totalLows++;
    runSeq(a2, a3, v5, v6, early, lows);
    totalLows += lows;
    nAssert++;
    if ({bus.slot_clr, bus.spr_lo, bus.spr_hi, a2, v5} !== {10'h200, 8'hB1, 8'hB2, 8'h0A, 13'h0212}) begin
      nFail++; $display("[TB] FAIL b2b_second: got clr %h lo %h hi %h oam_a %h vram_a %h expected 200 B1 B2 0A 0212",
                        bus.slot_clr, bus.spr_lo, bus.spr_hi, a2, v5);
    end
    nAssert++;
    if (totalLows !== 0) begin nFail++; $display("[TB] FAIL b2b_stall_continuous: got %0d low cycles expected 0", totalLows); end
    bus.match = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_bg_ready_hold();
    logic [7:0] a2, a3; logic [12:0] v5, v6; int early, lows, waitBad;
    setSlot(2, 6'd5, 4'd3);
    bgReady = 1'b0; bus.match = 10'h004;
    #1;
    waitBad = 0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (bus.stall !== 1'b1 || bus.oam_rd !== 1'b0) waitBad++;
    end
    @(posedge clk); #1;
    if (bus.oam_rd !== 1'b0) waitBad++;
    nAssert++;
    if (waitBad !== 0) begin nFail++; $display("[TB] FAIL bgready_wait: got %0d bad cycles expected 0", waitBad); end
    bgReady = 1'b1;
    #1;
    runSeq(a2, a3, v5, v6, early, lows);
    nAssert++;
    if ({a2, bus.spr_load, bus.spr_lo} !== {8'h16, 1'b1, 8'h5A}) begin
      nFail++; $display("[TB] FAIL bgready_start: got oam_a %h load %b lo %h expected 16 1 5A", a2, bus.spr_load, bus.spr_lo);
    end
    bus.match = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int bad;
    setSlot(2, 6'd5, 4'd3);
    bus.match = 10'h004;
    #1;
    for (int c = 2; c <= 6; c++) begin @(posedge clk); #1; end
    nAssert++;
    if ({bus.vram_rd, bus.vram_a} !== {1'b1, 13'h0427}) begin
      nFail++; $display("[TB] FAIL abort_in_t4: got rd %b vram_a %h expected 1 0427", bus.vram_rd, bus.vram_a);
    end
    lineEnd = 1'b1; bus.match = '0;
    #1;
    bad = (bus.spr_load !== 1'b0 || bus.slot_clr !== 10'h000) ? 1 : 0;
    @(posedge clk); #1;
    lineEnd = 1'b0;
    #1;
    nAssert++;
    if (bus.stall !== 1'b0) begin nFail++; $display("[TB] FAIL abort_idle: got stall %b expected 0", bus.stall); end
    for (int c = 0; c < 4; c++) begin
      if (bus.spr_load !== 1'b0 || bus.slot_clr !== 10'h000) bad++;
      @(posedge clk); #1;
    end
    nAssert++;
    if (bad !== 0) begin nFail++; $display("[TB] FAIL abort_no_load: got %0d load/clr cycles expected 0", bad); end
    nAssert++;
    if (bus.spr_lo !== 8'h5A) begin nFail++; $display("[TB] FAIL abort_hold_lo: got %h expected 5A", bus.spr_lo); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++)  oamMem[i]  = 8'h00;
    for (int i = 0; i < 8192; i++) vramMem[i] = 8'h00;
    test_reset();
    test_single_match();
    test_yflip_tall();
    test_xflip_macro();
    test_back_to_back();
    test_bg_ready_hold();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
